// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART serial receive stage. Synchronizes rx_i, recovers the
//               start / data (LSB first) / optional parity / stop bits using a
//               programmable clock divider, and presents each character on an
//               AXI-Stream-style output with a held-until-accepted handshake.
//               Optional feature macro: UART_RX_PARITY_EN (parity bit support).
// Ports       : clk_i, arstn_i (async active-low reset)
//               clk_divider_i   - clk_i cycles per bit (values < 4 act as 4)
//               parity_odd_i/parity_even_i - expected parity (odd wins)
//               rx_i            - serial line, idle high
//               m_axis_tdata_o/tuser_o/tvalid_o, m_axis_tready_i - output stream
//               frame_err_o     - pulse: stop bit sampled low
//               overrun_o       - pulse: character dropped, output still full
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH    = 8,
    parameter int DIVIDER_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic                     parity_odd_i,
    input  logic                     parity_even_i,
    input  logic                     rx_i,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
    output logic                     m_axis_tuser_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     frame_err_o,
    output logic                     overrun_o
);

    localparam int                        c_BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_BIT_CNT_W-1:0]    c_LAST_BIT  = c_BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_CNT_W-1:0]    c_BIT_ONE   = c_BIT_CNT_W'(1);
    localparam logic [DIVIDER_WIDTH-1:0]  c_MIN_DIV   = DIVIDER_WIDTH'(4);
    localparam logic [DIVIDER_WIDTH-1:0]  c_CNT_ONE   = DIVIDER_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [1:0]                 r_sync;
    logic                       w_rx_s;
    logic [DIVIDER_WIDTH-1:0]   r_div;
    logic [DIVIDER_WIDTH-1:0]   r_cnt;
    logic [DIVIDER_WIDTH-1:0]   w_half;
    logic [c_BIT_CNT_W-1:0]     r_bit_cnt;
    logic [DATA_WIDTH-1:0]      r_shift;
    logic                       w_tick;
    logic                       w_deliver;
    logic                       w_frame_err;
    logic [DATA_WIDTH-1:0]      r_tdata;
    logic                       r_tvalid;
    logic                       r_frame_err;
    logic                       r_overrun;

`ifdef UART_RX_PARITY_EN
    logic                       r_par_en;
    logic                       r_par_odd;
    logic                       r_perr;
    logic                       r_tuser;
    logic                       w_par_exp;

    assign w_par_exp = r_par_odd ? ~^r_shift : ^r_shift;
`else
    logic                       w_unused_parity;

    assign w_unused_parity = parity_odd_i | parity_even_i;
`endif

    assign w_rx_s = r_sync[1];
    assign w_half = r_div >> 1;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and per-cycle strobes. w_tick marks a bit sample point.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        w_deliver   = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == w_half) begin
                    w_tick      = 1'b1;
                    // A line that is high again at mid-start was a glitch.
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == r_div) begin
                    w_tick = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == r_div) begin
                    w_tick      = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == r_div) begin
                    w_tick = 1'b1;
                    if (w_rx_s) begin
                        // Return at mid-stop so a frame starting right after
                        // the stop bit is not missed.
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Synchronizer, bit timing and shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_sync    <= 2'b11;
            r_div     <= c_MIN_DIV;
            r_cnt     <= c_CNT_ONE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_sync <= {r_sync[0], rx_i};
            if (r_state == S_IDLE) begin
                // Configuration is re-captured every idle cycle; the value
                // from the cycle that sees the start edge holds for the frame.
                r_div     <= (clk_divider_i < c_MIN_DIV) ? c_MIN_DIV : clk_divider_i;
                r_cnt     <= c_CNT_ONE;
                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                r_par_en  <= parity_odd_i | parity_even_i;
                r_par_odd <= parity_odd_i;
                r_perr    <= 1'b0;
`endif
            end else if (w_tick) begin
                r_cnt <= c_CNT_ONE;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (r_state == S_DATA && w_tick) begin
                r_shift   <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
            end
`ifdef UART_RX_PARITY_EN
            if (r_state == S_PARITY && w_tick) begin
                r_perr <= (w_rx_s != w_par_exp);
            end
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Output stage: hold until accepted, drop new character when full
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_tuser     <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_tvalid || m_axis_tready_i) begin
                    r_tdata  <= r_shift;
                    r_tvalid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    r_tuser  <= r_perr;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tvalid && m_axis_tready_i) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata_o  = r_tdata;
    assign m_axis_tvalid_o = r_tvalid;
    assign frame_err_o     = r_frame_err;
    assign overrun_o       = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign m_axis_tuser_o  = r_tuser;
`else
    assign m_axis_tuser_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking testbench for uart_rx. Each scenario
//               task drives the serial line bit by bit and checks the stream
//               output, the status pulses and the output latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic        clk;
    logic        arstn_i;
    logic [31:0] clk_divider_i;
    logic        parity_odd_i;
    logic        parity_even_i;
    logic        rx_i;
    logic [7:0]  m_axis_tdata_o;
    logic        m_axis_tuser_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i;
    logic        frame_err_o;
    logic        overrun_o;

    int n_tests = 0;
    int n_fail  = 0;

    int          bit_cycles = 16;
    int          cyc        = 0;
    int          acc_cnt    = 0;
    int          fe_cnt     = 0;
    int          ov_cnt     = 0;
    int          valid_cyc  = 0;
    int          rise_cyc   = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  last_data  = 8'h00;
    logic [7:0]  prev_data  = 8'h00;
    logic        last_user  = 1'b0;

    uart_rx #(
        .DATA_WIDTH    (8),
        .DIVIDER_WIDTH (32)
    ) dut (
        .clk_i           (clk),
        .arstn_i         (arstn_i),
        .clk_divider_i   (clk_divider_i),
        .parity_odd_i    (parity_odd_i),
        .parity_even_i   (parity_even_i),
        .rx_i            (rx_i),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tuser_o  (m_axis_tuser_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .frame_err_o     (frame_err_o),
        .overrun_o       (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Observes the stream and pulses on the falling edge.
    always @(negedge clk) begin
        if (m_axis_tvalid_o) valid_cyc = valid_cyc + 1;
        if (m_axis_tvalid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = m_axis_tvalid_o;
        if (m_axis_tvalid_o && m_axis_tready_i) begin
            acc_cnt   = acc_cnt + 1;
            prev_data = last_data;
            last_data = m_axis_tdata_o;
            last_user = m_axis_tuser_o;
        end
        if (frame_err_o) fe_cnt = fe_cnt + 1;
        if (overrun_o)   ov_cnt = ov_cnt + 1;
    end

    task automatic bit_time(input logic b);
        rx_i = b;
        repeat (bit_cycles) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * bit_cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par,
                              input logic pbit, input logic stop_b);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        if (with_par) bit_time(pbit);
        bit_time(stop_b);
        rx_i = 1'b1;
    endtask

    task automatic test_reset;
        arstn_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (m_axis_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid_o); end
        n_tests++; if (m_axis_tdata_o !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got %h expected 00", m_axis_tdata_o); end
        n_tests++; if (m_axis_tuser_o !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b expected 0", m_axis_tuser_o); end
        n_tests++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err_o); end
        n_tests++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
        arstn_i = 1'b1;
        idle_bits(1);
        n_tests++; if (m_axis_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_tvalid: got %b expected 0", m_axis_tvalid_o); end
    endtask

    task automatic test_basic;
        int a0, v0, c0;
        a0 = acc_cnt; v0 = valid_cyc; c0 = cyc;
        send_frame(8'hA5, 0, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", acc_cnt - a0); end
        n_tests++; if (last_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h expected a5", last_data); end
        n_tests++; if (last_user !== 1'b0) begin n_fail++; $display("FAIL basic_user: got %b expected 0", last_user); end
        n_tests++; if (valid_cyc - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d expected 1", valid_cyc - v0); end
        // 2 sync + 8 (half bit) + 9*16 to mid-stop + 1 register stage
        n_tests++; if (rise_cyc - c0 !== 155) begin n_fail++; $display("FAIL basic_latency: got %0d expected 155", rise_cyc - c0); end
    endtask

    task automatic test_min_divider;
        int a0, c0;
        clk_divider_i = 32'd2;
        bit_cycles    = 4;
        idle_bits(1);
        a0 = acc_cnt; c0 = cyc;
        send_frame(8'hC3, 0, 1'b0, 1'b1);
        idle_bits(3);
        n_tests++; if (last_data !== 8'hC3 || acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL mindiv_data: got %h count %0d expected c3 count 1", last_data, acc_cnt - a0); end
        // divider clamps to 4: 2 + 2 + 9*4 + 1
        n_tests++; if (rise_cyc - c0 !== 41) begin n_fail++; $display("FAIL mindiv_latency: got %0d expected 41", rise_cyc - c0); end
        clk_divider_i = 32'd16;
        bit_cycles    = 16;
        idle_bits(1);
    endtask

    task automatic test_parity;
        int a0;
`ifdef UART_RX_PARITY_EN
        parity_even_i = 1'b1; parity_odd_i = 1'b0;
        a0 = acc_cnt;
        send_frame(8'h07, 1, 1'b1, 1'b1);
        idle_bits(2);
        n_tests++; if (last_data !== 8'h07 || acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL par_even_ok_data: got %h expected 07", last_data); end
        n_tests++; if (last_user !== 1'b0) begin n_fail++; $display("FAIL par_even_ok_user: got %b expected 0", last_user); end
        send_frame(8'h07, 1, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (last_data !== 8'h07 || acc_cnt - a0 !== 2) begin n_fail++; $display("FAIL par_even_bad_data: got %h expected 07", last_data); end
        n_tests++; if (last_user !== 1'b1) begin n_fail++; $display("FAIL par_even_bad_user: got %b expected 1", last_user); end
        parity_even_i = 1'b0; parity_odd_i = 1'b1;
        send_frame(8'h07, 1, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (last_data !== 8'h07 || acc_cnt - a0 !== 3) begin n_fail++; $display("FAIL par_odd_data: got %h expected 07", last_data); end
        n_tests++; if (last_user !== 1'b0) begin n_fail++; $display("FAIL par_odd_user: got %b expected 0", last_user); end
`else
        // Parity inputs have no effect: frame carries no parity bit.
        parity_even_i = 1'b1; parity_odd_i = 1'b1;
        a0 = acc_cnt;
        send_frame(8'h07, 0, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (last_data !== 8'h07 || acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL nopar_data: got %h count %0d expected 07 count 1", last_data, acc_cnt - a0); end
        n_tests++; if (last_user !== 1'b0) begin n_fail++; $display("FAIL nopar_user: got %b expected 0", last_user); end
`endif
        parity_even_i = 1'b0; parity_odd_i = 1'b0;
    endtask

    task automatic test_glitch;
        int a0, f0;
        a0 = acc_cnt; f0 = fe_cnt;
        rx_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle_bits(2);
        n_tests++; if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d expected 0", acc_cnt - a0); end
        n_tests++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_no_frame_err: got %0d expected 0", fe_cnt - f0); end
        send_frame(8'h3C, 0, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (last_data !== 8'h3C || acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL glitch_next_frame: got %h count %0d expected 3c count 1", last_data, acc_cnt - a0); end
    endtask

    task automatic test_frame_err;
        int a0, f0;
        a0 = acc_cnt; f0 = fe_cnt;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(((8'h55 >> i) & 8'h01) != 0);
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b0);
        idle_bits(2);
        n_tests++; if (fe_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - f0); end
        n_tests++; if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d expected 0", acc_cnt - a0); end
        send_frame(8'h81, 0, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (last_data !== 8'h81 || acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL ferr_recover: got %h count %0d expected 81 count 1", last_data, acc_cnt - a0); end
        n_tests++; if (fe_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_single: got %0d expected 1", fe_cnt - f0); end
    endtask

    task automatic test_back_to_back;
        int a0;
        a0 = acc_cnt;
        send_frame(8'h12, 0, 1'b0, 1'b1);
        send_frame(8'h34, 0, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (acc_cnt - a0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", acc_cnt - a0); end
        n_tests++; if (prev_data !== 8'h12 || last_data !== 8'h34) begin n_fail++; $display("FAIL b2b_data: got %h %h expected 12 34", prev_data, last_data); end
    endtask

    task automatic test_overrun;
        int a0, o0;
        m_axis_tready_i = 1'b0;
        a0 = acc_cnt; o0 = ov_cnt;
        send_frame(8'h11, 0, 1'b0, 1'b1);
        send_frame(8'h22, 0, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (m_axis_tvalid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_held_valid: got %b expected 1", m_axis_tvalid_o); end
        n_tests++; if (m_axis_tdata_o !== 8'h11) begin n_fail++; $display("FAIL ovr_held_data: got %h expected 11", m_axis_tdata_o); end
        n_tests++; if (ov_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d expected 1", ov_cnt - o0); end
        m_axis_tready_i = 1'b1;
        @(posedge clk);
        #1;
        m_axis_tready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL ovr_accept_count: got %0d expected 1", acc_cnt - a0); end
        n_tests++; if (last_data !== 8'h11) begin n_fail++; $display("FAIL ovr_accept_data: got %h expected 11", last_data); end
        n_tests++; if (m_axis_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_drained: got %b expected 0", m_axis_tvalid_o); end
        m_axis_tready_i = 1'b1;
    endtask

    task automatic test_reset_midframe;
        int a0;
        m_axis_tready_i = 1'b0;
        send_frame(8'h5A, 0, 1'b0, 1'b1);
        idle_bits(1);
        n_tests++; if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'h5A) begin n_fail++; $display("FAIL rst_pre_held: got %b %h expected 1 5a", m_axis_tvalid_o, m_axis_tdata_o); end
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        arstn_i = 1'b0;
        #1;
        n_tests++; if (m_axis_tvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_tvalid: got %b expected 0", m_axis_tvalid_o); end
        n_tests++; if (m_axis_tdata_o !== 8'h00) begin n_fail++; $display("FAIL rst_async_tdata: got %h expected 00", m_axis_tdata_o); end
        rx_i = 1'b1;
        m_axis_tready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        arstn_i = 1'b1;
        idle_bits(2);
        a0 = acc_cnt;
        send_frame(8'hF0, 0, 1'b0, 1'b1);
        idle_bits(2);
        n_tests++; if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL rst_after_count: got %0d expected 1", acc_cnt - a0); end
        n_tests++; if (last_data !== 8'hF0) begin n_fail++; $display("FAIL rst_after_data: got %h expected f0", last_data); end
    endtask

    initial begin
        arstn_i         = 1'b0;
        clk_divider_i   = 32'd16;
        parity_odd_i    = 1'b0;
        parity_even_i   = 1'b0;
        rx_i            = 1'b1;
        m_axis_tready_i = 1'b1;
        test_reset;
        test_basic;
        test_min_divider;
        test_parity;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_overrun;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
